// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port SRAM between two requesters.
// Port A (CPU) uses a level request and has fixed priority. Port B (video/DMA)
// issues read-only requests through a toggle handshake.
// Each access is IDLE -> SETUP -> STROBE (WAIT_CYCLES) -> HOLD -> IDLE, and every output is registered.
// Optional feature macro: RAM_ARB_STARVE_GUARD_EN. When it is defined, B is granted after
// STARVE_LIMIT consecutive A grants that were made while B was pending.
module ram_arbiter #(
    parameter int unsigned ADDR_W       = 21,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_memory,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_rd_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_done,
    input  logic              b_req_t,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack_t,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_dq_oe,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    // The strobe counter is loaded on entry to STROBE and counts down to zero.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_wait_cnt, w_wait_cnt_nxt;
    logic              r_is_a, w_is_a_nxt;
    logic              r_is_rd, w_is_rd_nxt;
    logic              r_a_served, w_a_served_nxt;
    logic [ADDR_W-1:0] r_sram_addr, w_sram_addr_nxt;
    logic [DATA_W-1:0] r_sram_dout, w_sram_dout_nxt;
    logic              r_dq_oe, w_dq_oe_nxt;
    logic              r_oe_n, w_oe_n_nxt;
    logic              r_we_n, w_we_n_nxt;
    logic [DATA_W-1:0] r_a_rdata, w_a_rdata_nxt;
    logic [DATA_W-1:0] r_b_rdata, w_b_rdata_nxt;
    logic              r_a_done, w_a_done_nxt;
    logic              r_b_ack_t, w_b_ack_t_nxt;

    logic w_a_pend;
    logic w_b_pend;
    logic w_force_b;
    logic w_grant_a;
    logic w_grant_b;

    assign w_a_pend  = a_req & ~r_a_served;
    assign w_b_pend  = b_req_t ^ r_b_ack_t;
    assign w_grant_a = (r_state == S_IDLE) & w_a_pend & ~w_force_b;
    assign w_grant_b = (r_state == S_IDLE) & w_b_pend & ~w_grant_a;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve_cnt;

    assign w_force_b = w_b_pend & (r_starve_cnt >= STARVE_W'(STARVE_LIMIT));

    // Count A grants made while B waits; clear when B is served or no longer pending.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!w_b_pend || w_grant_b) begin
            r_starve_cnt <= '0;
        end else if (w_grant_a) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force_b = 1'b0;
`endif

    // Register the state and all registered outputs.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_is_a      <= 1'b0;
            r_is_rd     <= 1'b0;
            r_a_served  <= 1'b0;
            r_sram_addr <= '0;
            r_sram_dout <= '0;
            r_dq_oe     <= 1'b0;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_a_done    <= 1'b0;
            r_b_ack_t   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_is_a      <= w_is_a_nxt;
            r_is_rd     <= w_is_rd_nxt;
            r_a_served  <= w_a_served_nxt;
            r_sram_addr <= w_sram_addr_nxt;
            r_sram_dout <= w_sram_dout_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_we_n      <= w_we_n_nxt;
            r_a_rdata   <= w_a_rdata_nxt;
            r_b_rdata   <= w_b_rdata_nxt;
            r_a_done    <= w_a_done_nxt;
            r_b_ack_t   <= w_b_ack_t_nxt;
        end
    end

    // Next-state and next-output decode for the access sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_is_a_nxt      = r_is_a;
        w_is_rd_nxt     = r_is_rd;
        w_sram_addr_nxt = r_sram_addr;
        w_sram_dout_nxt = r_sram_dout;
        w_dq_oe_nxt     = r_dq_oe;
        w_oe_n_nxt      = r_oe_n;
        w_we_n_nxt      = r_we_n;
        w_a_rdata_nxt   = r_a_rdata;
        w_b_rdata_nxt   = r_b_rdata;
        w_a_done_nxt    = 1'b0;
        w_b_ack_t_nxt   = r_b_ack_t;

        // a_served blocks a re-grant until a_req has been seen low.
        if (!a_req) begin
            w_a_served_nxt = 1'b0;
        end else if (w_grant_a) begin
            w_a_served_nxt = 1'b1;
        end else begin
            w_a_served_nxt = r_a_served;
        end

        case (r_state)
            S_IDLE: begin
                if (w_grant_a) begin
                    w_state_nxt     = S_SETUP;
                    w_is_a_nxt      = 1'b1;
                    w_is_rd_nxt     = ~a_rd_n;
                    w_sram_addr_nxt = a_addr;
                    w_sram_dout_nxt = a_wdata;
                    w_dq_oe_nxt     = a_rd_n;
                end else if (w_grant_b) begin
                    w_state_nxt     = S_SETUP;
                    w_is_a_nxt      = 1'b0;
                    w_is_rd_nxt     = 1'b1;
                    w_sram_addr_nxt = b_addr;
                end
            end
            S_SETUP: begin
                w_state_nxt    = S_STROBE;
                w_wait_cnt_nxt = WAIT_LOAD;
                if (r_is_rd) begin
                    w_oe_n_nxt = 1'b0;
                end else begin
                    w_we_n_nxt = 1'b0;
                end
            end
            S_STROBE: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = S_HOLD;
                    w_oe_n_nxt  = 1'b1;
                    w_we_n_nxt  = 1'b1;
                    if (r_is_a) begin
                        w_a_done_nxt = 1'b1;
                        if (r_is_rd) begin
                            w_a_rdata_nxt = sram_din;
                        end
                    end else begin
                        w_b_rdata_nxt = sram_din;
                        w_b_ack_t_nxt = ~r_b_ack_t;
                    end
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
                w_dq_oe_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign a_rdata    = r_a_rdata;
    assign a_done     = r_a_done;
    assign b_rdata    = r_b_rdata;
    assign b_ack_t    = r_b_ack_t;
    assign sram_addr  = r_sram_addr;
    assign sram_dout  = r_sram_dout;
    assign sram_dq_oe = r_dq_oe;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a behavioural SRAM model plus scoreboard queues of expected read data.
module tb_ram_arbiter;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_req;
    logic              a_rd_n;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_done;
    logic              b_req_t;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_rdata;
    logic              b_ack_t;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout;
    logic [DATA_W-1:0] sram_din;
    logic              sram_dq_oe;
    logic              sram_oe_n;
    logic              sram_we_n;

    logic [7:0] mem [0:255];
    logic [7:0] exp_a_q [$];
    logic [7:0] exp_b_q [$];
    logic [7:0] exp_a_rdata;
    logic [7:0] exp_b_rdata;
    logic [7:0] popped;
    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(2), .STARVE_LIMIT(4)) dut (
        .clk_memory(clk), .reset(reset),
        .a_req(a_req), .a_rd_n(a_rd_n), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_done(a_done),
        .b_req_t(b_req_t), .b_addr(b_addr), .b_rdata(b_rdata), .b_ack_t(b_ack_t),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    initial forever #5 clk = ~clk;

    // Asynchronous SRAM: read data only while OE is low; writes land while WE is low.
    assign sram_din = sram_oe_n ? 8'hEE : mem[sram_addr[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hC3;
        mem[8'h10] = 8'h11;
        mem[8'h20] = 8'h7E;
        forever begin
            @(negedge clk);
            if (sram_we_n === 1'b0) mem[sram_addr[7:0]] = sram_dout;
        end
    end

    task test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n: got %b expected 1", sram_oe_n); end
        n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b expected 1", sram_we_n); end
        n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_dq_oe: got %b expected 0", sram_dq_oe); end
        n_checks++; if (sram_addr !== 21'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", sram_addr); end
        n_checks++; if (sram_dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got %h expected 00", sram_dout); end
        n_checks++; if (a_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_a_rdata: got %h expected 00", a_rdata); end
        n_checks++; if (b_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_b_rdata: got %h expected 00", b_rdata); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rst_a_done: got %b expected 0", a_done); end
        n_checks++; if (b_ack_t !== 1'b0) begin n_fail++; $display("FAIL rst_b_ack: got %b expected 0", b_ack_t); end
    endtask

    task test_a_write;
        logic exp_we_n;
        @(posedge clk); #1;
        a_addr = 21'h1ABCD; a_wdata = 8'h5A; a_rd_n = 1'b1; a_req = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            exp_we_n = (cyc == 2 || cyc == 3) ? 1'b0 : 1'b1;
            n_checks++; if (sram_we_n !== exp_we_n) begin n_fail++; $display("FAIL wr_we_n c%0d: got %b expected %b", cyc, sram_we_n, exp_we_n); end
            n_checks++; if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL wr_oe_n c%0d: got %b expected 1", cyc, sram_oe_n); end
            n_checks++; if (sram_dq_oe !== (cyc <= 4)) begin n_fail++; $display("FAIL wr_dq_oe c%0d: got %b expected %b", cyc, sram_dq_oe, cyc <= 4); end
            n_checks++; if (a_done !== (cyc == 4)) begin n_fail++; $display("FAIL wr_done c%0d: got %b expected %b", cyc, a_done, cyc == 4); end
            if (cyc <= 4) begin
                n_checks++; if (sram_addr !== 21'h1ABCD) begin n_fail++; $display("FAIL wr_addr c%0d: got %h expected 1abcd", cyc, sram_addr); end
                n_checks++; if (sram_dout !== 8'h5A) begin n_fail++; $display("FAIL wr_dout c%0d: got %h expected 5a", cyc, sram_dout); end
            end
            if (cyc == 4) a_req = 1'b0;
        end
    endtask

    task test_b_read;
        logic ack0;
        logic exp_oe_n;
        ack0 = b_ack_t;
        @(posedge clk); #1;
        b_addr = 21'h00100; b_req_t = ~b_req_t; exp_b_q.push_back(8'hC3);
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            exp_oe_n = (cyc == 2 || cyc == 3) ? 1'b0 : 1'b1;
            n_checks++; if (sram_oe_n !== exp_oe_n) begin n_fail++; $display("FAIL brd_oe_n c%0d: got %b expected %b", cyc, sram_oe_n, exp_oe_n); end
            n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL brd_we_n c%0d: got %b expected 1", cyc, sram_we_n); end
            n_checks++; if (b_ack_t !== (cyc >= 4 ? ~ack0 : ack0)) begin n_fail++; $display("FAIL brd_ack c%0d: got %b expected %b", cyc, b_ack_t, cyc >= 4 ? ~ack0 : ack0); end
            if (cyc == 4) begin
                popped = exp_b_q.pop_front(); exp_b_rdata = popped;
                n_checks++; if (b_rdata !== popped) begin n_fail++; $display("FAIL brd_data: got %h expected %h", b_rdata, popped); end
                n_checks++; if (a_rdata !== exp_a_rdata) begin n_fail++; $display("FAIL brd_a_rdata_kept: got %h expected %h", a_rdata, exp_a_rdata); end
            end
        end
    endtask

    task test_collision;
        logic ack0;
        int a_done_cyc, b_grant_cyc, ack_cyc;
        ack0 = b_ack_t; a_done_cyc = 0; b_grant_cyc = 0; ack_cyc = 0;
        @(posedge clk); #1;
        a_addr = 21'h00010; a_rd_n = 1'b0; a_req = 1'b1; exp_a_q.push_back(8'h11);
        b_addr = 21'h00020; b_req_t = ~b_req_t; exp_b_q.push_back(8'h7E);
        @(posedge clk);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 2) a_req = 1'b0;
            if (a_done === 1'b1 && a_done_cyc == 0) begin
                a_done_cyc = cyc;
                popped = exp_a_q.pop_front(); exp_a_rdata = popped;
                n_checks++; if (a_rdata !== popped) begin n_fail++; $display("FAIL col_a_rdata: got %h expected %h", a_rdata, popped); end
                n_checks++; if (b_rdata !== exp_b_rdata) begin n_fail++; $display("FAIL col_b_rdata_kept: got %h expected %h", b_rdata, exp_b_rdata); end
            end
            if (sram_addr === 21'h00020 && b_grant_cyc == 0) b_grant_cyc = cyc;
            if (b_ack_t !== ack0 && ack_cyc == 0) begin
                ack_cyc = cyc;
                popped = exp_b_q.pop_front(); exp_b_rdata = popped;
                n_checks++; if (b_rdata !== popped) begin n_fail++; $display("FAIL col_b_data: got %h expected %h", b_rdata, popped); end
                n_checks++; if (a_rdata !== exp_a_rdata) begin n_fail++; $display("FAIL col_a_rdata_kept: got %h expected %h", a_rdata, exp_a_rdata); end
            end
        end
        n_checks++; if (a_done_cyc != 4) begin n_fail++; $display("FAIL col_a_done_cycle: got %0d expected 4", a_done_cyc); end
        n_checks++; if (b_grant_cyc != 6) begin n_fail++; $display("FAIL col_b_grant_cycle: got %0d expected 6", b_grant_cyc); end
        n_checks++; if (ack_cyc != 9) begin n_fail++; $display("FAIL col_ack_cycle: got %0d expected 9", ack_cyc); end
    endtask

    task test_held_request;
        int strobes, dones;
        logic prev_oe_n;
        strobes = 0; dones = 0; prev_oe_n = 1'b1;
        @(posedge clk); #1;
        a_addr = 21'h1ABCD; a_rd_n = 1'b0; a_req = 1'b1; exp_a_q.push_back(8'h5A);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (prev_oe_n === 1'b1 && sram_oe_n === 1'b0) strobes++;
            prev_oe_n = sram_oe_n;
            if (a_done === 1'b1) begin
                dones++;
                popped = exp_a_q.pop_front(); exp_a_rdata = popped;
                n_checks++; if (a_rdata !== popped) begin n_fail++; $display("FAIL held_rdata: got %h expected %h", a_rdata, popped); end
            end
        end
        a_req = 1'b0;
        n_checks++; if (strobes != 1) begin n_fail++; $display("FAIL held_strobes: got %0d expected 1", strobes); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL held_dones: got %0d expected 1", dones); end
        repeat (2) @(negedge clk);
    endtask

    task test_starvation;
        logic ack0;
        bit acked;
        int a_before_ack;
        ack0 = b_ack_t; acked = 0; a_before_ack = 0;
        @(posedge clk); #1;
        b_addr = 21'h00100; b_req_t = ~b_req_t; exp_b_q.push_back(8'hC3);
        a_addr = 21'h00010; a_rd_n = 1'b0; a_req = 1'b1; exp_a_q.push_back(8'h11);
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                popped = exp_a_q.pop_front(); exp_a_rdata = popped;
                n_checks++; if (a_rdata !== popped) begin n_fail++; $display("FAIL stv_a_rdata: got %h expected %h", a_rdata, popped); end
                if (!acked) a_before_ack++;
                a_req = 1'b0;
            end else if (a_req === 1'b0) begin
                a_req = 1'b1; exp_a_q.push_back(8'h11);
            end
            if (!acked && b_ack_t !== ack0) begin
                acked = 1;
                popped = exp_b_q.pop_front(); exp_b_rdata = popped;
                n_checks++; if (b_rdata !== popped) begin n_fail++; $display("FAIL stv_b_data: got %h expected %h", b_rdata, popped); end
            end
        end
`ifdef RAM_ARB_STARVE_GUARD_EN
        n_checks++; if (!acked) begin n_fail++; $display("FAIL stv_guard_ack: got 0 expected 1"); end
        n_checks++; if (a_before_ack != 4) begin n_fail++; $display("FAIL stv_guard_a_count: got %0d expected 4", a_before_ack); end
`else
        n_checks++; if (acked) begin n_fail++; $display("FAIL stv_strict_ack: got 1 expected 0"); end
        n_checks++; if (a_before_ack < 8) begin n_fail++; $display("FAIL stv_strict_a_count: got %0d expected >=8", a_before_ack); end
`endif
        // Stop pulsing A; any access in flight finishes, then B must get through.
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                popped = exp_a_q.pop_front(); exp_a_rdata = popped;
                n_checks++; if (a_rdata !== popped) begin n_fail++; $display("FAIL stv_tail_a_rdata: got %h expected %h", a_rdata, popped); end
                a_req = 1'b0;
            end
            if (!acked && b_ack_t !== ack0) begin
                acked = 1;
                popped = exp_b_q.pop_front(); exp_b_rdata = popped;
                n_checks++; if (b_rdata !== popped) begin n_fail++; $display("FAIL stv_tail_b_data: got %h expected %h", b_rdata, popped); end
            end
        end
        n_checks++; if (!acked) begin n_fail++; $display("FAIL stv_b_served: got 0 expected 1"); end
    endtask

    task test_reset_mid_access;
        bit found;
        int dones;
        found = 0; dones = 0;
        @(posedge clk); #1;
        a_addr = 21'h00055; a_wdata = 8'h99; a_rd_n = 1'b1; a_req = 1'b1;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (sram_we_n === 1'b0) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_strobe_seen: got 0 expected 1"); end
        #1;
        reset = 1'b1; a_req = 1'b0; b_req_t = 1'b0;
        #1;
        n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rmid_we_n: got %b expected 1", sram_we_n); end
        n_checks++; if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL rmid_oe_n: got %b expected 1", sram_oe_n); end
        n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_dq_oe: got %b expected 0", sram_dq_oe); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rmid_a_done: got %b expected 0", a_done); end
        n_checks++; if (b_ack_t !== 1'b0) begin n_fail++; $display("FAIL rmid_b_ack: got %b expected 0", b_ack_t); end
        exp_a_rdata = 8'h00; exp_b_rdata = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (a_done === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d expected 0", dones); end
        n_checks++; if (sram_addr !== 21'h0) begin n_fail++; $display("FAIL rmid_idle_addr: got %h expected 0", sram_addr); end
        a_addr = 21'h00010; a_rd_n = 1'b0; a_req = 1'b1; exp_a_q.push_back(8'h11);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                dones++;
                popped = exp_a_q.pop_front(); exp_a_rdata = popped;
                n_checks++; if (a_rdata !== popped) begin n_fail++; $display("FAIL rmid_after_rdata: got %h expected %h", a_rdata, popped); end
                a_req = 1'b0;
            end
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL rmid_after_done: got %0d expected 1", dones); end
    endtask

    initial begin
        reset = 1'b1; a_req = 1'b0; a_rd_n = 1'b0; a_addr = '0; a_wdata = '0;
        b_req_t = 1'b0; b_addr = '0;
        exp_a_rdata = 8'h00; exp_b_rdata = 8'h00;
        test_reset();
        test_a_write();
        test_b_read();
        test_collision();
        test_held_request();
        test_starvation();
        test_reset_mid_access();
        n_checks++; if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drained: got a=%0d b=%0d expected 0 0", exp_a_q.size(), exp_b_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
